// File: rtl/qspi_pkg.sv
// qspi_pkg: shared types and constants for the QSPI fetch buffer.
//   qspi_fetch_state_e : fill FSM states (IDLE / REQ / GAP)
//   QSPI_ADDR_W        : flash byte-address width
//   QSPI_DATA_W        : fetch / APB data width
//   qspi_idx_w()       : word-index width for a given line size
package qspi_pkg;

    localparam int unsigned QSPI_ADDR_W = 24;
    localparam int unsigned QSPI_DATA_W = 32;

    typedef enum logic [1:0] {
        QSPI_FETCH_IDLE = 2'd0,
        QSPI_FETCH_REQ  = 2'd1,
        QSPI_FETCH_GAP  = 2'd2
    } qspi_fetch_state_e;

    // log2 of a power-of-two line size (2..16 words)
    function automatic int unsigned qspi_idx_w(input int unsigned line_words);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            if ((32'd1 << i) < line_words) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/qspi_fetch_buffer_if.sv
// qspi_fetch_buffer_if: core fetch port + APB-style read port of the flash controller.
//   master : view of the fetch buffer (drives req_ready/rsp_* and the m_* select side)
//   slave  : view of the environment (core requester + flash controller)
interface qspi_fetch_buffer_if;
    import qspi_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic [31:0]            req_addr;
    logic                   rsp_valid;
    logic [QSPI_DATA_W-1:0] rsp_data;
    logic                   flush_i;
    logic [31:0]            m_paddr;
    logic                   m_psel;
    logic                   m_pwrite;
    logic                   m_pready;
    logic [QSPI_DATA_W-1:0] m_prdata;

    modport master (
        input  req_valid, req_addr, flush_i, m_pready, m_prdata,
        output req_ready, rsp_valid, rsp_data, m_paddr, m_psel, m_pwrite
    );

    modport slave (
        output req_valid, req_addr, flush_i, m_pready, m_prdata,
        input  req_ready, rsp_valid, rsp_data, m_paddr, m_psel, m_pwrite
    );

endinterface

// File: rtl/qspi_fetch_buffer.sv
// qspi_fetch_buffer: single-line, critical-word-first instruction fetch buffer
// in front of the QSPI flash controller's APB-style read port.
//   s_pclk    : clock
//   s_preset  : synchronous active-high reset
//   bus       : qspi_fetch_buffer_if.master (req_*/rsp_*/flush_i and m_* controller port)
//   hit_cnt_o, miss_cnt_o : saturating access counters, present only when
//                           QSPI_FETCH_STATS_EN is defined
// Hits answer one cycle after accept. A miss refills the whole line starting at
// the requested word, one APB read per word with a single idle cycle between reads.
module qspi_fetch_buffer
    import qspi_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = QSPI_ADDR_W
) (
    input  logic                s_pclk,
    input  logic                s_preset,
    qspi_fetch_buffer_if.master bus
`ifdef QSPI_FETCH_STATS_EN
    ,
    output logic [31:0]         hit_cnt_o,
    output logic [31:0]         miss_cnt_o
`endif
);

    localparam int unsigned IDX_W   = qspi_idx_w(LINE_WORDS);
    localparam int unsigned TAG_LSB = IDX_W + 2;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;

    qspi_fetch_state_e      state_q, state_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       crit_q, crit_d;
    logic [LINE_WORDS-1:0]  wvalid_q, wvalid_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [QSPI_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                   m_psel_q, m_psel_d;
    logic [31:0]            m_paddr_q, m_paddr_d;
    logic [QSPI_DATA_W-1:0] line_q [LINE_WORDS];

    logic                   wr_en_c;
    logic [IDX_W-1:0]       req_idx_c;
    logic [TAG_W-1:0]       req_tag_c;
    logic [IDX_W-1:0]       idx_inc_c;
    logic                   accept_c;
    logic                   hit_c;
    logic                   miss_c;
    logic                   unused_addr_bits;

    // Request decode; req_ready_q is only high while in IDLE
    assign req_idx_c = bus.req_addr[TAG_LSB-1:2];
    assign req_tag_c = bus.req_addr[ADDR_W-1:TAG_LSB];
    assign idx_inc_c = idx_q + IDX_W'(1);
    assign accept_c  = bus.req_valid & req_ready_q;
    // A flush in the accept cycle forces the request to be treated as a miss
    assign hit_c     = accept_c & ~bus.flush_i & wvalid_q[req_idx_c] & (req_tag_c == tag_q);
    assign miss_c    = accept_c & ~hit_c;

    assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W], bus.req_addr[1:0]};

    // State register
    always_ff @(posedge s_pclk) begin
        if (s_preset) begin
            state_q <= QSPI_FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of all registered outputs / line bookkeeping
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        crit_d       = crit_q;
        wvalid_d     = wvalid_q;
        flush_pend_d = flush_pend_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        m_psel_d     = m_psel_q;
        m_paddr_d    = m_paddr_q;
        wr_en_c      = 1'b0;

        unique case (state_q)
            QSPI_FETCH_IDLE: begin
                if (bus.flush_i) begin
                    wvalid_d = '0;
                end
                if (hit_c) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = line_q[req_idx_c];
                end else if (miss_c) begin
                    tag_d     = req_tag_c;
                    idx_d     = req_idx_c;
                    crit_d    = req_idx_c;
                    wvalid_d  = '0;
                    m_paddr_d = 32'({req_tag_c, req_idx_c, 2'b00});
                    m_psel_d  = 1'b1;
                    state_d   = QSPI_FETCH_REQ;
                end
            end
            QSPI_FETCH_REQ: begin
                if (bus.flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.m_pready) begin
                    wr_en_c         = 1'b1;
                    wvalid_d[idx_q] = 1'b1;
                    m_psel_d        = 1'b0;
                    state_d         = QSPI_FETCH_GAP;
                    // Only the first beat of a fill lands on the critical word
                    if (idx_q == crit_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = bus.m_prdata;
                    end
                end
            end
            QSPI_FETCH_GAP: begin
                idx_d = idx_inc_c;
                // Wrapping back to the critical word means every beat is done
                if (idx_inc_c == crit_q) begin
                    state_d      = QSPI_FETCH_IDLE;
                    flush_pend_d = 1'b0;
                    if (flush_pend_q || bus.flush_i) begin
                        wvalid_d = '0;
                    end
                end else begin
                    if (bus.flush_i) begin
                        flush_pend_d = 1'b1;
                    end
                    m_paddr_d = 32'({tag_q, idx_inc_c, 2'b00});
                    m_psel_d  = 1'b1;
                    state_d   = QSPI_FETCH_REQ;
                end
            end
            default: begin
                state_d = QSPI_FETCH_IDLE;
            end
        endcase

        req_ready_d = (state_d == QSPI_FETCH_IDLE);
    end

    // Registered outputs and line bookkeeping
    always_ff @(posedge s_pclk) begin
        if (s_preset) begin
            tag_q        <= '0;
            idx_q        <= '0;
            crit_q       <= '0;
            wvalid_q     <= '0;
            flush_pend_q <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            m_psel_q     <= 1'b0;
            m_paddr_q    <= '0;
        end else begin
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            crit_q       <= crit_d;
            wvalid_q     <= wvalid_d;
            flush_pend_q <= flush_pend_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            m_psel_q     <= m_psel_d;
            m_paddr_q    <= m_paddr_d;
        end
    end

    // Line storage; contents are qualified by wvalid_q so no reset is needed
    always_ff @(posedge s_pclk) begin
        if (wr_en_c) begin
            line_q[idx_q] <= bus.m_prdata;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.m_psel    = m_psel_q;
    assign bus.m_paddr   = m_paddr_q;
    assign bus.m_pwrite  = 1'b0;

`ifdef QSPI_FETCH_STATS_EN
    // Saturating hit / miss counters; flush does not clear them
    always_ff @(posedge s_pclk) begin
        if (s_preset) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit_c && (hit_cnt_o != 32'hFFFF_FFFF)) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (miss_c && (miss_cnt_o != 32'hFFFF_FFFF)) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/qspi_fetch_buffer.md
Name: qspi_fetch_buffer

Overview:
- Single-line, critical-word-first read buffer between the core instruction-fetch port and the QSPI flash controller's APB-style read port.
- Hits return in 1 cycle.
- Misses refill the whole line through sequential one-word APB reads. The buffer is the only master of the controller.
- Masks the roughly 30-cycle per-word flash latency for straight-line code.

Parameters:
- LINE_WORDS, 4: 32-bit words per line. Power of two, 2..16.
- ADDR_W, 24: flash byte-address width. Bits above ADDR_W are ignored.

Ports:
- s_pclk  in  1  clock.
- s_preset  in  1  synchronous active-high reset.
- req_valid  in  1  core fetch request.
- req_ready  out  1  buffer accepts a request this cycle.
- req_addr  in  32  byte address. Bits [1:0] are ignored.
- rsp_valid  out  1  one-cycle pulse; the core must accept it (no backpressure).
- rsp_data  out  32  fetched word; valid only with rsp_valid.
- flush_i  in  1  invalidate the line.
- m_paddr  out  32  to controller s_paddr.
- m_psel  out  1  to controller s_psel.
- m_pwrite  out  1  tied to 0.
- m_pready  in  1  controller completion pulse.
- m_prdata  in  32  controller read data.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, m_psel=0, m_paddr=0. Line valid bits and tag are cleared; FSM goes to IDLE; the flush-pending flag is cleared.
- Reset during a fill drops m_psel on the next edge. The controller shares the same reset.
- Address split:
  - word index = addr[LOG2(LINE_WORDS)+1:2]
  - tag = addr[ADDR_W-1:LOG2(LINE_WORDS)+2]
- FSM states: IDLE, REQ, GAP.
  - IDLE: req_ready=1. On req_valid, the request is accepted.
    - Hit (line valid and tag match): rsp_valid=1 next cycle with the stored word. Stay in IDLE, so back-to-back hits give 1 response per cycle.
    - Miss: latch tag and critical index; clear all word-valid bits; m_paddr = {tag, critical index, 2'b00}; m_psel=1 next cycle; go to REQ.
  - REQ: m_psel held at 1 and m_paddr stable until m_pready=1.
    - On m_pready: write m_prdata into the word at the current index and set that word's valid bit; m_psel=0 on the next edge; go to GAP.
    - If the written word is the pending word, rsp_valid=1 and rsp_data=that word next cycle.
  - GAP: exactly one cycle with m_psel=0, so the controller returns to its idle state before the next select.
    - Increment the index modulo LINE_WORDS (wrap-around).
    - If LINE_WORDS beats are done, go to IDLE; otherwise go to REQ with the new m_paddr.
- req_ready=0 in REQ and GAP. A line fill always completes before the next request is accepted.
- Miss latency from the accept edge: 1 cycle to m_psel, plus controller latency, plus 1 cycle to rsp_valid.
- flush_i:
  - In IDLE: clears valid bits on the next edge. A request accepted in that same cycle is treated as a miss.
  - In REQ or GAP: sets a sticky flush-pending flag. The fill and the critical-word response complete normally (the controller transaction cannot be aborted). The line is invalidated on entry to IDLE.
- m_pwrite is always 0. The buffer never issues a write.

Optional Feature:
- QSPI_FETCH_STATS_EN
  - Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0], which saturate at 32'hFFFF_FFFF.
    - hit_cnt_o increments on each accepted hit.
    - miss_cnt_o increments on each accepted miss.
    - Both reset to 0. flush_i does not clear them.
  - Undefined: the ports and counters are absent and there is no other behavioural change.

Decomposition:
- Package qspi_pkg holds:
  - the fetch FSM enum (QSPI_FETCH_IDLE, QSPI_FETCH_REQ, QSPI_FETCH_GAP);
  - the constant QSPI_ADDR_W=24;
  - a function computing word-index width from LINE_WORDS.
- No sub-module is required. The line storage is a flop array inside the block.

Test Plan:
- Cold miss: with LINE_WORDS=4, request 0x000104.
  - m_paddr sequence is 0x104, 0x108, 0x10C, 0x100, with one m_psel-low cycle between beats.
  - rsp_valid fires once, the cycle after the first m_pready, with the model data for 0x104.
- Hit stream: after the fill above, requests 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
  - Four rsp_valid pulses on consecutive cycles with the matching data.
  - m_psel stays 0.
- Tag conflict: request 0x000200 after the 0x100 line is filled.
  - New fill starts at 0x200.
  - A later request to 0x100 misses again.
- Flush during fill: assert flush_i in the second REQ beat of a miss on 0x040.
  - All 4 beats complete and the critical word is returned.
  - A subsequent request to 0x044 is a miss.
- Reset mid-REQ: assert s_preset while m_psel=1.
  - Next cycle m_psel=0, req_ready=0, rsp_valid=0.
  - After reset releases, request 0x040 is a miss.
- With QSPI_FETCH_STATS_EN, run the cold-miss and hit-stream scenarios: miss_cnt_o=1, hit_cnt_o=4.
